// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - opcodes, sequencer states and helpers for datapath_seq
package datapath_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    T_Y   = 3'd1,
    T_Z   = 3'd2,
    T_WLO = 3'd3,
    T_WHI = 3'd4,
    DONE  = 3'd5
  } state_t;

  // MUL/DIV results go to LO/HI instead of the register file
  function automatic logic is_hilo_op(input logic [4:0] opcode);
    return (opcode == OP_MUL) || (opcode == OP_DIV);
  endfunction

endpackage

// File: rtl/datapath_seq_alu.sv
// rtl/datapath_seq_alu.sv - combinational ALU producing a 2*WIDTH result
module alu_core
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         opcode,
  output logic [2*WIDTH-1:0] result
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]             sh;
  logic [2*WIDTH-1:0]        rot_r;
  logic [2*WIDTH-1:0]        rot_l;
  logic signed [WIDTH-1:0]   sa;
  logic signed [WIDTH-1:0]   sb;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]          lo;
  logic [WIDTH-1:0]          hi;

  assign sh    = b[SW-1:0];
  assign rot_r = {a, a} >> sh;
  assign rot_l = {a, a} << sh;
  assign sa    = a;
  assign sb    = b;
  assign prod  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

  always_comb begin
    lo = '0;
    hi = '0;
    case (opcode)
      OP_ADD:  lo = a + b;
      OP_SUB:  lo = a - b;
      OP_AND:  lo = a & b;
      OP_OR:   lo = a | b;
      OP_SHR:  lo = a >> sh;
      OP_SHRA: lo = sa >>> sh;
      OP_SHL:  lo = a << sh;
      OP_ROR:  lo = rot_r[WIDTH-1:0];
      OP_ROL:  lo = rot_l[2*WIDTH-1:WIDTH];
      OP_MUL: begin
        lo = prod[WIDTH-1:0];
        hi = prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        // divide-by-zero and most-negative/-1 are pinned to fixed results
        if (b == '0) begin
          lo = '1;
          hi = a;
        end else if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
          lo = a;
          hi = '0;
        end else begin
          lo = sa / sb;
          hi = sa % sb;
        end
      end
      OP_NEG:  lo = -a;
      OP_NOT:  lo = ~a;
      default: lo = '0;
    endcase
    result = {hi, lo};
  end

endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - single-bus datapath with register file and built-in micro-sequencer
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [4:0]               ALU_opcode,
  input  logic [$clog2(NREGS)-1:0] ra,
  input  logic [$clog2(NREGS)-1:0] rb,
  input  logic [$clog2(NREGS)-1:0] rc,
  input  logic                     ext_we,
  input  logic [$clog2(NREGS)-1:0] ext_addr,
  input  logic [WIDTH-1:0]         ext_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         bus,
  output logic [WIDTH-1:0]         HI,
  output logic [WIDTH-1:0]         LO,
  output logic [WIDTH-1:0]         Y,
  output logic [2*WIDTH-1:0]       Z_register
);

  localparam int AW = $clog2(NREGS);

  state_t             state, next_state;
  logic [4:0]         op_q;
  logic [AW-1:0]      ra_q, rb_q, rc_q;
  logic [WIDTH-1:0]   regs [NREGS];
  logic [WIDTH-1:0]   rb_val, rc_val;
  logic [2*WIDTH-1:0] alu_out;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [WIDTH-1:0]   rf_wdata;
  logic               hilo;

  assign hilo    = is_hilo_op(op_q);
  assign rd_data = (R0_ZERO != 0 && rd_addr == '0) ? '0 : regs[rd_addr];
  assign rb_val  = (R0_ZERO != 0 && rb_q == '0) ? '0 : regs[rb_q];
  assign rc_val  = (R0_ZERO != 0 && rc_q == '0) ? '0 : regs[rc_q];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = T_Y;
      T_Y:     next_state = T_Z;
      T_Z:     next_state = T_WLO;
      T_WLO:   next_state = hilo ? T_WHI : DONE;
      T_WHI:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    bus  = '0;
    case (state)
      T_Y:   begin busy = 1'b1; bus = rb_val; end
      T_Z:   begin busy = 1'b1; bus = rc_val; end
      T_WLO: begin busy = 1'b1; bus = Z_register[WIDTH-1:0]; end
      T_WHI: begin busy = 1'b1; bus = Z_register[2*WIDTH-1:WIDTH]; end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a      (Y),
    .b      (bus),
    .opcode (op_q),
    .result (alu_out)
  );

  // Single register-file write port shared by external loads and write-back
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (state == IDLE && ext_we) begin
      rf_we    = 1'b1;
      rf_waddr = ext_addr;
      rf_wdata = ext_data;
    end else if (state == T_WLO && !hilo) begin
      rf_we    = 1'b1;
      rf_waddr = ra_q;
      rf_wdata = bus;
    end
    if (R0_ZERO != 0 && rf_waddr == '0) rf_we = 1'b0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      rc_q       <= '0;
      Y          <= '0;
      Z_register <= '0;
      HI         <= '0;
      LO         <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q <= ALU_opcode;
          ra_q <= ra;
          rb_q <= rb;
          rc_q <= rc;
        end
        T_Y:   Y <= bus;
        T_Z:   Z_register <= alu_out;
        T_WLO: if (hilo) LO <= bus;
        T_WHI: HI <= bus;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// tb/tb_datapath_seq.sv - scoreboard bench for datapath_seq
module tb_datapath_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [4:0]  ALU_opcode;
  logic [3:0]  ra, rb, rc;
  logic        ext_we;
  logic [3:0]  ext_addr;
  logic [31:0] ext_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy, done;
  logic [31:0] bus, HI, LO, Y;
  logic [63:0] Z_register;

  int checks = 0;
  int errors = 0;
  int bcnt   = 0;

  typedef struct {
    string       name;
    logic [63:0] z;
    bit          hilo;
    int          bcyc;
  } exp_t;

  exp_t expq[$];

  datapath_seq #(.WIDTH(32), .NREGS(16), .R0_ZERO(1)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .ALU_opcode (ALU_opcode),
    .ra         (ra),
    .rb         (rb),
    .rc         (rc),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_data   (ext_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .bus        (bus),
    .HI         (HI),
    .LO         (LO),
    .Y          (Y),
    .Z_register (Z_register)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation
  always @(negedge clk) begin
    exp_t e;
    if (!clr) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          chk({e.name, "_busy_cycles"}, 64'(bcnt), 64'(e.bcyc));
          if (e.hilo) begin
            chk({e.name, "_LO"}, {32'd0, LO}, {32'd0, e.z[31:0]});
            chk({e.name, "_HI"}, {32'd0, HI}, {32'd0, e.z[63:32]});
          end else begin
            chk({e.name, "_Z"}, Z_register, e.z);
          end
        end
        bcnt = 0;
      end
    end
  end

  task automatic ext_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    ext_we = 1'b1; ext_addr = a; ext_data = d;
    @(posedge clk);
    #1 ext_we = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    rd_addr = a;
    #1 chk(nm, {32'd0, rd_data}, {32'd0, exp});
  endtask

  task automatic run_op(input string nm, input logic [4:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c, input logic [63:0] z,
                        input bit meddle, input bit with_ext,
                        input logic [3:0] ea, input logic [31:0] ed);
    int  n;
    bit  got;
    bit  h;
    h = (op == 5'd9) || (op == 5'd10);
    @(negedge clk);
    start = 1'b1; ALU_opcode = op; ra = a; rb = b; rc = c;
    if (with_ext) begin
      ext_we = 1'b1; ext_addr = ea; ext_data = ed;
    end
    expq.push_back('{nm, z, h, h ? 4 : 3});
    @(posedge clk);
    #1 start = 1'b0; ext_we = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (meddle && n == 2) begin
        start = 1'b1; ext_we = 1'b1; ext_addr = 4'd13; ext_data = 32'd55;
        @(posedge clk);
        #1 start = 1'b0; ext_we = 1'b0;
      end
    end
    chk({nm, "_done_cycle"}, 64'(n), h ? 64'd5 : 64'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b0; start = 1'b0; ALU_opcode = '0; ra = '0; rb = '0; rc = '0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_bus",  {32'd0, bus}, 64'd0);
    chk("rst_Z",    Z_register, 64'd0);
    chk("rst_HILO", {HI, LO}, 64'd0);
    clr = 1'b1;

    ext_wr(4'd2, 32'd5);
    ext_wr(4'd3, 32'd7);
    run_op("add", 5'd0, 4'd1, 4'd2, 4'd3, 64'd12, 0, 0, 4'd0, 32'd0);
    chk("add_Y", {32'd0, Y}, 64'd5);
    rd_chk("add_R1", 4'd1, 32'd12);

    ext_wr(4'd4, 32'hFFFF_FFFA);
    ext_wr(4'd5, 32'd4);
    run_op("mul", 5'd9, 4'd10, 4'd4, 4'd5, 64'hFFFF_FFFF_FFFF_FFE8, 0, 0, 4'd0, 32'd0);
    rd_chk("mul_ra_unchanged", 4'd10, 32'd0);

    ext_wr(4'd6, 32'hFFFF_FFF9);
    ext_wr(4'd7, 32'd2);
    run_op("div", 5'd10, 4'd10, 4'd6, 4'd7, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 0, 4'd0, 32'd0);
    ext_wr(4'd7, 32'd0);
    run_op("div0", 5'd10, 4'd10, 4'd6, 4'd7, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 0, 0, 4'd0, 32'd0);
    ext_wr(4'd11, 32'h8000_0000);
    ext_wr(4'd12, 32'hFFFF_FFFF);
    run_op("divovf", 5'd10, 4'd10, 4'd11, 4'd12, {32'h0, 32'h8000_0000}, 0, 0, 4'd0, 32'd0);

    ext_wr(4'd0, 32'd9);
    rd_chk("r0_ext_discard", 4'd0, 32'd0);
    run_op("add_r0", 5'd0, 4'd0, 4'd2, 4'd3, 64'd12, 1, 0, 4'd0, 32'd0);
    rd_chk("r0_wb_discard", 4'd0, 32'd0);
    rd_chk("busy_ext_dropped", 4'd13, 32'd0);

    run_op("add_same_cycle_ext", 5'd0, 4'd15, 4'd14, 4'd14, 64'd200, 0, 1, 4'd14, 32'd100);
    rd_chk("same_cycle_R15", 4'd15, 32'd200);

    ext_wr(4'd8, 32'd1);
    ext_wr(4'd9, 32'd35);
    run_op("shl", 5'd6, 4'd1, 4'd8, 4'd9, 64'd8, 0, 0, 4'd0, 32'd0);
    rd_chk("shl_R1", 4'd1, 32'd8);
    ext_wr(4'd13, 32'd1);
    run_op("ror", 5'd7, 4'd1, 4'd8, 4'd13, 64'h8000_0000, 0, 0, 4'd0, 32'd0);
    run_op("shra", 5'd5, 4'd12, 4'd4, 4'd13, 64'hFFFF_FFFD, 0, 0, 4'd0, 32'd0);
    run_op("not", 5'd12, 4'd1, 4'd0, 4'd5, 64'hFFFF_FFFF, 0, 0, 4'd0, 32'd0);
    rd_chk("not_R1", 4'd1, 32'hFFFF_FFFF);
    run_op("sub", 5'd1, 4'd5, 4'd2, 4'd3, 64'hFFFF_FFFE, 0, 0, 4'd0, 32'd0);
    run_op("rsvd", 5'd20, 4'd2, 4'd3, 4'd3, 64'd0, 0, 0, 4'd0, 32'd0);
    rd_chk("rsvd_R2", 4'd2, 32'd0);

    @(negedge clk);
    start = 1'b1; ALU_opcode = 5'd0; ra = 4'd1; rb = 4'd3; rc = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_regs", {Y, bus}, 64'd0);
    chk("abort_Z", Z_register, 64'd0);
    chk("abort_HILO", {HI, LO}, 64'd0);
    rd_chk("abort_R1", 4'd1, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    ext_wr(4'd2, 32'd3);
    ext_wr(4'd3, 32'd4);
    run_op("add_after_abort", 5'd0, 4'd1, 4'd2, 4'd3, 64'd7, 0, 0, 4'd0, 32'd0);
    rd_chk("after_abort_R1", 4'd1, 32'd7);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
